// File: rtl/windowed_reg_file.sv
// Windowed register file: NUM_WIN overlapping windows laid over a circular
// physical array, with a call/return window pointer and depth tracking.
module windowed_reg_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int NUM_WIN = 4,
  parameter int STRIDE  = 2,
  parameter int BYPASS  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          readReg1,
  input  logic [ADDR_W-1:0]          readReg2,
  input  logic [ADDR_W-1:0]          writeReg,
  input  logic [DATA_W-1:0]          writeData,
  input  logic                       writeEn,
  input  logic                       winPush,
  input  logic                       winPop,
  output logic [DATA_W-1:0]          readData1,
  output logic [DATA_W-1:0]          readData2,
  output logic [$clog2(NUM_WIN)-1:0] cwp,
  output logic [$clog2(NUM_WIN)-1:0] depth,
  output logic                       winOvf,
  output logic                       winUnf
);

  localparam int PHYS = NUM_WIN * STRIDE;
  localparam int PW   = $clog2(PHYS);
  localparam int CW   = $clog2(NUM_WIN);
  localparam int SW   = PW + ADDR_W + 1;

  typedef enum logic [1:0] {
    WIN_HOLD,
    WIN_PUSH,
    WIN_POP
  } win_op_e;

  // Window-relative index to physical entry; truncation gives the wrap of
  // the last window onto window 0.
  function automatic logic [PW-1:0] phys(input logic [CW-1:0]     c,
                                         input logic [ADDR_W-1:0] idx);
    logic [SW-1:0] sum;
    sum = SW'(c) * SW'(STRIDE) + SW'(idx);
    return sum[PW-1:0];
  endfunction

  logic [DATA_W-1:0] mem [PHYS];
  logic [PW-1:0]     phys_rd1, phys_rd2, phys_wr;

  assign phys_rd1 = phys(cwp, readReg1);
  assign phys_rd2 = phys(cwp, readReg2);
  assign phys_wr  = phys(cwp, writeReg);

  // NOTE: the array is a flop bank, not RAM, so it can honour the async clear;
  // non-blocking assignments keep the write ordered against same-edge reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHYS; i++) mem[i] <= '0;
    end else if (writeEn) begin
      mem[phys_wr] <= writeData;
    end
  end

  // Bypass is masked during reset so the ports read zero while it is held.
  // NOTE: defaults first in every always_comb so no path infers a latch.
  always_comb begin
    readData1 = mem[phys_rd1];
    readData2 = mem[phys_rd2];
    if (BYPASS != 0 && rst && writeEn) begin
      if (phys_wr == phys_rd1) readData1 = writeData;
      if (phys_wr == phys_rd2) readData2 = writeData;
    end
  end

  win_op_e         win_op;
  logic [CW-1:0]   cwp_next, depth_next;
  logic            ovf_next, unf_next;

  always_comb begin
    win_op     = WIN_HOLD;
    cwp_next   = cwp;
    depth_next = depth;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;
    if (winPush && !winPop) win_op = WIN_PUSH;
    if (winPop && !winPush) win_op = WIN_POP;
    case (win_op)
      WIN_PUSH: begin
        if (depth == CW'(NUM_WIN - 1)) begin
          ovf_next = 1'b1;
        end else begin
          cwp_next   = cwp + CW'(1);
          depth_next = depth + CW'(1);
        end
      end
      WIN_POP: begin
        if (depth == '0) begin
          unf_next = 1'b1;
        end else begin
          cwp_next   = cwp - CW'(1);
          depth_next = depth - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cwp    <= '0;
      depth  <= '0;
      winOvf <= 1'b0;
      winUnf <= 1'b0;
    end else begin
      cwp    <= cwp_next;
      depth  <= depth_next;
      winOvf <= ovf_next;
      winUnf <= unf_next;
    end
  end

endmodule

// File: tb/tb_windowed_reg_file.sv
// Scoreboard bench for windowed_reg_file: one bypassing and one non-bypassing
// instance share stimulus; a behavioural model feeds expectations to a queue.
module tb_windowed_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rr1, rr2, wr;
  logic [15:0] wd;
  logic        we, push, pop;

  logic [15:0] rd1a, rd2a, rd1b, rd2b;
  logic [1:0]  cwp_a, depth_a, cwp_b, depth_b;
  logic        ovf_a, unf_a, ovf_b, unf_b;

  always #5 clk = ~clk;

  windowed_reg_file #(.DATA_W(16), .ADDR_W(2), .NUM_WIN(4), .STRIDE(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .readReg1(rr1), .readReg2(rr2), .writeReg(wr),
    .writeData(wd), .writeEn(we), .winPush(push), .winPop(pop),
    .readData1(rd1a), .readData2(rd2a), .cwp(cwp_a), .depth(depth_a),
    .winOvf(ovf_a), .winUnf(unf_a));

  windowed_reg_file #(.DATA_W(16), .ADDR_W(2), .NUM_WIN(4), .STRIDE(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .readReg1(rr1), .readReg2(rr2), .writeReg(wr),
    .writeData(wd), .writeEn(we), .winPush(push), .winPop(pop),
    .readData1(rd1b), .readData2(rd2b), .cwp(cwp_b), .depth(depth_b),
    .winOvf(ovf_b), .winUnf(unf_b));

  typedef enum int {K_RD1A, K_RD2A, K_RD1B, K_RD2B, K_CWP, K_DEPTH, K_OVF, K_UNF, K_CWPB, K_DEPTHB} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] exp;
    string       tag;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;

  logic [15:0] m_mem [8];
  int          m_cwp, m_depth;
  bit          m_ovf, m_unf;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic int phys(input int c, input int idx);
    return (c * 2 + idx) % 8;
  endfunction

  function automatic logic [15:0] observed(input kind_e k);
    case (k)
      K_RD1A:  return rd1a;
      K_RD2A:  return rd2a;
      K_RD1B:  return rd1b;
      K_RD2B:  return rd2b;
      K_CWP:   return 16'(cwp_a);
      K_DEPTH: return 16'(depth_a);
      K_OVF:   return 16'(ovf_a);
      K_UNF:   return 16'(unf_a);
      K_CWPB:  return 16'(cwp_b);
      default: return 16'(depth_b);
    endcase
  endfunction

  task automatic push_item(input kind_e k, input logic [15:0] exp, input string tag);
    item_t it;
    it.kind = k;
    it.exp  = exp;
    it.tag  = tag;
    sb.push_back(it);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_cwp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Expectations for everything visible right now, given current inputs.
  task automatic expect_all(input string tag);
    logic [15:0] old1, old2;
    bit          byp;
    old1 = rst ? m_mem[phys(m_cwp, rr1)] : 16'h0;
    old2 = rst ? m_mem[phys(m_cwp, rr2)] : 16'h0;
    byp  = rst && we;
    push_item(K_RD1A, (byp && phys(m_cwp, wr) == phys(m_cwp, rr1)) ? wd : old1, {tag, ".rd1a"});
    push_item(K_RD2A, (byp && phys(m_cwp, wr) == phys(m_cwp, rr2)) ? wd : old2, {tag, ".rd2a"});
    push_item(K_RD1B, old1, {tag, ".rd1b"});
    push_item(K_RD2B, old2, {tag, ".rd2b"});
    push_item(K_CWP, 16'(m_cwp), {tag, ".cwp"});
    push_item(K_DEPTH, 16'(m_depth), {tag, ".depth"});
    push_item(K_OVF, 16'(m_ovf), {tag, ".ovf"});
    push_item(K_UNF, 16'(m_unf), {tag, ".unf"});
    push_item(K_CWPB, 16'(m_cwp), {tag, ".cwpb"});
    push_item(K_DEPTHB, 16'(m_depth), {tag, ".depthb"});
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check(it.tag, observed(it.kind), it.exp);
    end
  endtask

  task automatic model_update();
    if (!rst) return;
    if (we) m_mem[phys(m_cwp, wr)] = wd;
    m_ovf = 0;
    m_unf = 0;
    if (push && !pop) begin
      if (m_depth < 3) begin m_cwp = (m_cwp + 1) % 4; m_depth++; end
      else m_ovf = 1;
    end else if (pop && !push) begin
      if (m_depth > 0) begin m_cwp = (m_cwp + 3) % 4; m_depth--; end
      else m_unf = 1;
    end
  endtask

  task automatic drive(input bit w, input logic [1:0] widx, input logic [15:0] wdata,
                       input bit pu, input bit po, input logic [1:0] r1, input logic [1:0] r2);
    we = w; wr = widx; wd = wdata; push = pu; pop = po; rr1 = r1; rr2 = r2;
  endtask

  // One full cycle: drive at negedge, compare mid-low phase, model on posedge.
  task automatic cyc(input string tag, input bit w, input logic [1:0] widx,
                     input logic [15:0] wdata, input bit pu, input bit po,
                     input logic [1:0] r1, input logic [1:0] r2);
    @(negedge clk);
    drive(w, widx, wdata, pu, po, r1, r2);
    #1;
    expect_all(tag);
    drain();
    @(posedge clk);
    model_update();
  endtask

  // Idle cycle that also pins read port 1 to a literal expected value.
  task automatic peek(input string tag, input logic [1:0] r1, input logic [15:0] exp);
    @(negedge clk);
    drive(0, 2'd0, 16'h0, 0, 0, r1, r1);
    #1;
    push_item(K_RD1A, exp, {tag, ".lit_a"});
    push_item(K_RD1B, exp, {tag, ".lit_b"});
    expect_all(tag);
    drain();
    @(posedge clk);
    model_update();
  endtask

  initial begin
    drive(0, 2'd0, 16'h0, 0, 0, 2'd0, 2'd0);
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) cyc($sformatf("reset_idx%0d", i), 0, 2'd0, 16'h0, 0, 0, 2'(i), 2'(3 - i));

    // overlap: reg2 of window 0 is reg0 of window 1
    cyc("ovl_wr", 1, 2'd2, 16'hABCD, 0, 0, 2'd0, 2'd2);
    cyc("ovl_push", 0, 2'd0, 16'h0, 1, 0, 2'd0, 2'd0);
    #1;
    check("ovl_cwp", 16'(cwp_a), 16'd1);
    check("ovl_depth", 16'(depth_a), 16'd1);
    peek("ovl_rd", 2'd0, 16'hABCD);

    // wrap: window 3 reg3 lands in physical entry 1
    cyc("wrap_push2", 0, 2'd0, 16'h0, 1, 0, 2'd0, 2'd1);
    cyc("wrap_push3", 0, 2'd0, 16'h0, 1, 0, 2'd0, 2'd1);
    cyc("wrap_wr", 1, 2'd3, 16'h1234, 0, 0, 2'd3, 2'd1);
    for (int i = 0; i < 3; i++) cyc($sformatf("wrap_pop%0d", i), 0, 2'd0, 16'h0, 0, 1, 2'd1, 2'd3);
    peek("wrap_rd", 2'd1, 16'h1234);
    check("wrap_cwp", 16'(cwp_a), 16'd0);

    // overflow and underflow pulses
    for (int i = 0; i < 3; i++) cyc($sformatf("ovf_push%0d", i), 0, 2'd0, 16'h0, 1, 0, 2'd0, 2'd1);
    cyc("ovf_reject", 0, 2'd0, 16'h0, 1, 0, 2'd0, 2'd1);
    #1;
    check("ovf_pulse", 16'(ovf_a), 16'd1);
    check("ovf_cwp", 16'(cwp_a), 16'd3);
    cyc("ovf_after", 0, 2'd0, 16'h0, 0, 0, 2'd0, 2'd1);
    #1;
    check("ovf_clear", 16'(ovf_a), 16'd0);
    for (int i = 0; i < 3; i++) cyc($sformatf("unf_pop%0d", i), 0, 2'd0, 16'h0, 0, 1, 2'd0, 2'd1);
    cyc("unf_reject", 0, 2'd0, 16'h0, 0, 1, 2'd0, 2'd1);
    #1;
    check("unf_pulse", 16'(unf_a), 16'd1);
    check("unf_cwp", 16'(cwp_a), 16'd0);
    cyc("unf_after", 0, 2'd0, 16'h0, 0, 0, 2'd0, 2'd1);

    // bypass: same-cycle value on dut_a, old value on dut_b
    cyc("byp_wr", 1, 2'd1, 16'h5A5A, 0, 0, 2'd1, 2'd1);
    peek("byp_next", 2'd1, 16'h5A5A);

    // write concurrent with push uses the pre-push window
    cyc("wp_wr", 1, 2'd3, 16'h0F0F, 1, 0, 2'd3, 2'd0);
    peek("wp_rd", 2'd1, 16'h0F0F);
    check("wp_cwp", 16'(cwp_a), 16'd1);
    cyc("pp_both", 0, 2'd0, 16'h0, 1, 1, 2'd0, 2'd1);
    cyc("pp_after", 0, 2'd0, 16'h0, 0, 0, 2'd0, 2'd1);

    // reset dropped mid-cycle with a matching write pending
    cyc("burst0", 1, 2'd2, 16'hC0DE, 1, 0, 2'd2, 2'd0);
    @(negedge clk);
    drive(1, 2'd1, 16'hBEEF, 1, 0, 2'd1, 2'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    expect_all("rst_mid");
    drain();
    @(posedge clk);
    #1;
    expect_all("rst_hold");
    drain();
    @(negedge clk);
    drive(0, 2'd0, 16'h0, 0, 0, 2'd0, 2'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("rst_rd%0d", i), 0, 2'd0, 16'h0, 0, 0, 2'(i), 2'(i ^ 1));

    for (int n = 0; n < 300; n++) begin
      cyc($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          16'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    cyc("final", 0, 2'd0, 16'h0, 0, 0, 2'd0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/windowed_reg_file.md
Name: windowed_reg_file

Overview:
- Parametrised successor to the single-cycle processor's 2-bit windowed register file.
- Holds NUM_WIN overlapping register windows in a circular physical array.
- A current-window pointer (CWP) is advanced and retreated by call/return requests, with nesting-depth tracking and overflow/underflow flags.
- Provides two combinational read ports, one synchronous write port and an optional write-to-read bypass.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 2, per-window register index width; 2^ADDR_W registers visible per window.
- NUM_WIN, 4, number of windows; power of 2, at least 2.
- STRIDE, 2, physical offset between adjacent windows; power of 2, at most 2^ADDR_W. Overlap per window is 2^ADDR_W - STRIDE.
- BYPASS, 1, 1 makes a same-cycle write visible on the read ports; 0 disables this.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- readReg1  in  ADDR_W  read port 1 register index within the current window.
- readReg2  in  ADDR_W  read port 2 register index within the current window.
- writeReg  in  ADDR_W  write register index within the current window.
- writeData  in  DATA_W  write data.
- writeEn  in  1  write enable.
- winPush  in  1  call request: advance CWP.
- winPop  in  1  return request: retreat CWP.
- readData1  out  DATA_W  read port 1 data, combinational.
- readData2  out  DATA_W  read port 2 data, combinational.
- cwp  out  log2(NUM_WIN)  current window pointer, registered.
- depth  out  log2(NUM_WIN)  nesting depth, registered.
- winOvf  out  1  registered one-cycle pulse: a push was rejected.
- winUnf  out  1  registered one-cycle pulse: a pop was rejected.

Behaviour:
- Physical array:
  - Size PHYS = NUM_WIN*STRIDE entries.
  - Physical index = (cwp*STRIDE + idx) mod PHYS, computed by truncation to log2(PHYS) bits.
  - The last window therefore wraps onto physical entries of window 0.
- Reset (rst=0, asynchronous):
  - All physical entries, cwp, depth, winOvf and winUnf are cleared to 0.
  - readData1/2 read 0 while reset is held.
  - Reset asserted mid-sequence aborts everything immediately, including a pending write.
- Reads:
  - readDataN = array[phys(cwp, readRegN)].
  - Purely combinational, zero latency, always using the registered cwp.
- Write:
  - When writeEn=1, array[phys(cwp, writeReg)] <= writeData on the clk rising edge.
  - The physical index uses the cwp value before any same-cycle push or pop.
- Bypass:
  - With BYPASS=1, writeEn=1 and phys(cwp, writeReg) == phys(cwp, readRegN), readDataN = writeData in the same cycle.
  - With BYPASS=0, readDataN returns the old value until the next cycle.
  - Both read ports can be bypassed in the same cycle.
- Window control, one state per depth 0..NUM_WIN-1, evaluated each rising edge:
  - winPush=1, winPop=0, depth < NUM_WIN-1: cwp <= cwp+1 (mod NUM_WIN), depth <= depth+1.
  - winPush=1, winPop=0, depth == NUM_WIN-1: no change; winOvf <= 1 for one cycle.
  - winPop=1, winPush=0, depth > 0: cwp <= cwp-1 (mod NUM_WIN), depth <= depth-1.
  - winPop=1, winPush=0, depth == 0: no change; winUnf <= 1 for one cycle.
  - winPush=1 and winPop=1 together: no-op; no flags raised.
  - All other cycles: winOvf <= 0 and winUnf <= 0.
- Register contents are never saved or cleared on push/pop; spilling is the controller's responsibility after winOvf.

Test Plan:
Defaults throughout: PHYS=8.
1. Reset: hold rst=0 for 3 cycles, then release -> cwp=0, depth=0, winOvf=winUnf=0, and readData1/2=0x0000 for every index.
2. Overlap: at cwp=0 write reg2=0xABCD, then push -> cwp=1, depth=1, readReg1=0 gives readData1=0xABCD (physical entry 2).
3. Wrap: push 3 times (cwp=3), write reg3=0x1234 (physical entry 1), pop 3 times -> cwp=0, readReg1=1 gives 0x1234.
4. Overflow/underflow:
   - At depth=3, push -> cwp stays 3 and winOvf=1 for exactly one cycle.
   - At depth=0, pop -> winUnf=1 for one cycle and cwp stays 0.
5. Bypass: writeEn=1, writeReg=readReg1=readReg2=1, writeData=0x5A5A -> BYPASS=1 gives both read ports 0x5A5A in the same cycle; BYPASS=0 gives the old value until the next cycle.
6. Simultaneous events:
   - writeEn with push, at cwp=0 reg3=0x0F0F -> data lands in physical entry 3, cwp=1, reg1 reads 0x0F0F.
   - Push and pop together -> no change and no flags.
   - Drop rst mid-burst -> all state is 0 immediately.
